// File: rtl/psg_bus_master.sv
// psg_bus_master: queues PSG register read/write requests and plays them out
// as BDIR/BC address-latch, write and read cycles.
//
// Ports:
//   CLK, RESET                  clock, async active-high reset
//   REQ_VALID/REQ_READY         request handshake (REQ_RD, REQ_ADDR, REQ_DATA)
//   RSP_VALID, RSP_DATA         one-cycle read response strobe and held data
//   BUSY                        FIFO non-empty or sequencer active
//   PSG_BDIR, PSG_BC            bus control to the PSG
//   PSG_DO, PSG_DI              data to / from the PSG
module psg_bus_master #(
  parameter int unsigned HOLD       = 2,
  parameter int unsigned GAP        = 1,
  parameter int unsigned DEPTH      = 4,
  parameter bit          CACHE_ADDR = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_RD,
  input  logic [3:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic       PSG_BDIR,
  output logic       PSG_BC,
  output logic [7:0] PSG_DO,
  input  logic [7:0] PSG_DI
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  HOLD_M1 = 4'(HOLD - 1);
  localparam logic [3:0]  GAP_M1  = 4'(GAP - 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP_A, S_XFER, S_GAP_X
  } state_t;

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ready_q, ready_d;
  state_t        st_q, st_d;
  logic [3:0]    ph_q, ph_d;
  req_t          cur_q, cur_d;
  logic [3:0]    cache_q, cache_d;
  logic          cvld_q, cvld_d;
  logic [7:0]    do_q, do_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rvld_q, rvld_d;
  logic          push, pop, hit;
  logic          bdir, bc;
  req_t          head;

  always_comb begin
    head  = mem_q[rp_q];
    push  = REQ_VALID & ready_q;
    pop   = (st_q == S_IDLE) & (cnt_q != '0);
    hit   = CACHE_ADDR & cvld_q & (cache_q == head.addr);
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
    // Ready is registered from the next count, so a full FIFO
    // never accepts on the same cycle a slot frees up.
    ready_d = (cnt_d < DEPTH_C);
  end

  always_comb begin
    st_d    = st_q;
    ph_d    = ph_q;
    cur_d   = cur_q;
    cache_d = cache_q;
    cvld_d  = cvld_q;
    do_d    = do_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    bdir    = 1'b0;
    bc      = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (pop) begin
          cur_d = head;
          ph_d  = HOLD_M1;
          if (hit) begin
            st_d = S_XFER;
            do_d = head.rd ? 8'h00 : head.data;
          end else begin
            st_d = S_ADDR;
            // upper nibble zero so the PSG always accepts the latch
            do_d = {4'b0000, head.addr};
          end
        end
      end
      S_ADDR: begin
        bdir    = 1'b1;
        bc      = 1'b1;
        cache_d = cur_q.addr;
        cvld_d  = 1'b1;
        if (ph_q == '0) begin
          st_d = S_GAP_A;
          ph_d = GAP_M1;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      S_GAP_A: begin
        // PSG acts on BDIR rising, so the bus must drop between phases
        if (ph_q == '0) begin
          st_d = S_XFER;
          ph_d = HOLD_M1;
          do_d = cur_q.rd ? 8'h00 : cur_q.data;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      S_XFER: begin
        bdir = ~cur_q.rd;
        bc   = cur_q.rd;
        if (ph_q == '0) begin
          st_d = S_GAP_X;
          ph_d = GAP_M1;
          if (cur_q.rd) begin
            rdata_d = PSG_DI;
            rvld_d  = 1'b1;
          end
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      S_GAP_X: begin
        if (ph_q == '0) st_d = S_IDLE;
        else            ph_d = ph_q - 1'b1;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wp_q] <= '{REQ_RD, REQ_ADDR, REQ_DATA};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      st_q    <= S_IDLE;
      ph_q    <= '0;
      cur_q   <= '0;
      cache_q <= '0;
      cvld_q  <= 1'b0;
      do_q    <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      st_q    <= st_d;
      ph_q    <= ph_d;
      cur_q   <= cur_d;
      cache_q <= cache_d;
      cvld_q  <= cvld_d;
      do_q    <= do_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
    end
  end

  // Bus controls decode straight from the state flop so reset
  // drops them without waiting for a clock.
  assign PSG_BDIR  = bdir;
  assign PSG_BC    = bc;
  assign PSG_DO    = do_q;
  assign REQ_READY = ready_q;
  assign RSP_VALID = rvld_q;
  assign RSP_DATA  = rdata_q;
  assign BUSY      = (cnt_q != '0) | (st_q != S_IDLE);

endmodule

// File: doc/psg_bus_master.md
Name: psg_bus_master

Overview:
- Initiator side of the PSG BDIR/BC bus: converts queued register read/write requests into correctly timed address-latch, write and read cycles for the ym2149 PSG.
- Sits between a CPU-side or player-side request source and the PSG.
- Buffers requests in a small FIFO.
- Skips redundant address-latch cycles.
- Returns read data on a one-cycle response strobe.

Parameters:
- HOLD, 2, cycles each active bus phase (address/write/read) is held; legal 1..15.
- GAP, 1, inactive cycles (BDIR=0, BC=0) after each active phase; legal 1..15.
- DEPTH, 4, request FIFO entries; power of 2, legal 2..16.
- CACHE_ADDR, 1, 1 = skip the address phase when the request address equals the last latched address.

Ports:
- CLK  in  1  global clock
- RESET  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  request offered
- REQ_READY  out  1  FIFO can accept; transfer when REQ_VALID & REQ_READY
- REQ_RD  in  1  1 = register read, 0 = register write
- REQ_ADDR  in  4  PSG register number
- REQ_DATA  in  8  write data; ignored for reads
- RSP_VALID  out  1  one-cycle pulse, read data valid
- RSP_DATA  out  8  read data, held until next read completes
- BUSY  out  1  FIFO non-empty or sequencer not IDLE
- PSG_BDIR  out  1  to PSG BDIR
- PSG_BC  out  1  to PSG BC
- PSG_DO  out  8  to PSG DI
- PSG_DI  in  8  from PSG DO

Behaviour:
- Reset: one clock, CLK; asynchronous active-high RESET. While RESET is high, all outputs are 0: BDIR, BC, PSG_DO, RSP_VALID, RSP_DATA, REQ_READY, BUSY. The FIFO is flushed, the address cache is invalidated and the state machine goes to IDLE.
- Reset mid-transaction: the bus goes inactive immediately (asynchronously) and the aborted request is lost. The first cycle after reset release has REQ_READY=1.
- FIFO:
  - REQ_READY = (count < DEPTH), registered; no same-cycle full bypass.
  - Push and pop in the same cycle leave count unchanged.
  - Entry stores {rd, addr, data}.
- States: IDLE, ADDR, GAP_A, XFER, GAP_X. A phase counter counts HOLD or GAP cycles.
- IDLE:
  - BDIR=0, BC=0.
  - If the FIFO is non-empty: pop the head into a working register.
  - Next state is XFER when CACHE_ADDR=1, the cache is valid and the cache equals the popped addr. Otherwise it is ADDR.
- ADDR, HOLD cycles:
  - BDIR=1, BC=1, PSG_DO={4'b0000, addr}. The upper nibble is forced to 0 so the PSG always accepts the latch.
  - Sets cache=addr, valid=1.
  - Next: GAP_A.
- GAP_A, GAP cycles: BDIR=0, BC=0, PSG_DO holds its value. This gap is required because the PSG acts on the BDIR rising edge.
- XFER, HOLD cycles:
  - Write: BDIR=1, BC=0, PSG_DO=data.
  - Read: BDIR=0, BC=1, PSG_DO=0.
  - For a read, PSG_DI is sampled on the last XFER cycle. RSP_DATA updates and RSP_VALID pulses in the following cycle (the first GAP_X cycle).
- GAP_X, GAP cycles: BDIR=0, BC=0. Next: IDLE.
- Latency, from first IDLE cycle with a non-empty FIFO to return to IDLE:
  - Uncached: 1+2*HOLD+2*GAP cycles (7 at defaults).
  - Cached: 1+HOLD+GAP cycles (4 at defaults).
- The PSG sees exactly one BDIR rising edge per ADDR phase and per write XFER. Read XFER produces no BDIR edge.
- Ordering: requests execute strictly in FIFO order. Each request issues exactly one response per read and none per write.
- BUSY=0 only when the FIFO is empty and the state is IDLE.
- The cache is written only in ADDR. It is never invalidated except by RESET.

Test Plan:
- Reset: assert RESET mid-ADDR phase -> BDIR and BC go 0 in the same cycle, no clock needed. After release: REQ_READY=1, BUSY=0, next write performs a full ADDR phase.
- Single write, reg 7 = 0x38, defaults:
  - BDIR/BC sequence 11,11,00,10,10,00.
  - PSG_DO = 0x07 during ADDR, 0x38 during XFER.
  - Connected ym2149 reads back 0x38 from reg 7.
  - Total 7 cycles.
- Cached write: write reg 8 = 0x0F, then reg 8 = 0x1F -> second request has no ADDR phase and takes 4 cycles. With CACHE_ADDR=0 both requests take 7 cycles.
- Read: write reg 0 = 0xA5, then read reg 0 -> RSP_VALID pulses once with RSP_DATA=0xA5. The read has no BDIR=1 during XFER.
- FIFO full: push DEPTH+1 requests back-to-back while the sequencer runs -> REQ_READY drops after count reaches 4, no request is lost or duplicated, and the PSG receives all of them in order.
- Address boundary: write reg 15 = 0xFF, then reg 0 = 0x00 -> PSG_DO=0x0F during ADDR (upper nibble zero), and both registers are updated correctly.
